// File: rtl/ahb_sram_slave_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_sram_slave_pkg
//  Purpose  : Shared AHB-Lite encodings, FSM state codes and byte-lane helper
//             for the AHB SRAM responder.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package ahb_sram_slave_pkg;

    // htrans encodings
    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] c_HTRANS_SEQ    = 2'b11;

    // hsize encodings supported by a 32-bit slave
    localparam logic [2:0] c_HSIZE_BYTE = 3'b000;
    localparam logic [2:0] c_HSIZE_HALF = 3'b001;
    localparam logic [2:0] c_HSIZE_WORD = 3'b010;

    // hresp encodings
    localparam logic c_HRESP_OKAY  = 1'b0;
    localparam logic c_HRESP_ERROR = 1'b1;

    // Responder FSM state codes
    localparam int         c_STATE_W  = 3;
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_WAIT  = 3'd1;
    localparam logic [2:0] c_ST_DATA  = 3'd2;
    localparam logic [2:0] c_ST_ERR1  = 3'd3;
    localparam logic [2:0] c_ST_ERR2  = 3'd4;

    // Little-endian byte-lane enables for a legal (already checked) access.
    function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] ofs);
        case (size)
            c_HSIZE_BYTE: lane_mask = 4'b0001 << ofs;
            c_HSIZE_HALF: lane_mask = ofs[1] ? 4'b1100 : 4'b0011;
            c_HSIZE_WORD: lane_mask = 4'b1111;
            default:      lane_mask = 4'b0000;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_sram_slave_if.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_sram_slave_if
//  Purpose  : AHB-Lite slave-slot bundle: address/control/write data towards
//             the slave, hrdata/hreadyout/hresp back to the response mux.
//  Ports    : master modport drives request + hready; slave modport drives
//             the response triple.
//  Revision : 1.0 - initial release
// ============================================================================
interface ahb_sram_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  hsel;
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic                  hwrite;
    logic [2:0]            hsize;
    logic [DATA_WIDTH-1:0] hwdata;
    logic                  hready;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  hreadyout;
    logic                  hresp;

    // hready is the fed-back response-mux output; the system side drives it.
    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        input  hrdata, hreadyout, hresp
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hwdata, hready,
        output hrdata, hreadyout, hresp
    );
endinterface
`default_nettype wire

// File: rtl/ahb_sram_slave_core.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_sram_slave_core
//  Purpose  : Single-port MEM_DEPTH x 32 word array with per-byte write
//             enables and a combinational read on the word index.
//  Ports    : clk     - clock
//             i_we    - byte write enables (lane 0 = bits 7:0)
//             i_idx   - word index (shared by read and write)
//             i_wdata - write data
//             o_rdata - word at i_idx
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_sram_slave_core #(
    parameter int MEM_DEPTH = 256,
    parameter int IDX_W     = 8
) (
    input  wire              clk,
    input  wire [3:0]        i_we,
    input  wire [IDX_W-1:0]  i_idx,
    input  wire [31:0]       i_wdata,
    output logic [31:0]      o_rdata
);
    // Contents are deliberately not reset.
    logic [31:0] r_mem_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                r_mem_q[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    assign o_rdata = r_mem_q[i_idx];
endmodule
`default_nettype wire

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_sram_slave
//  Purpose  : AHB-Lite responder backed by a word SRAM. Inserts WAIT_STATES
//             wait cycles on OKAY transfers and a two-cycle ERROR response on
//             out-of-range, oversized or misaligned accesses.
//  Ports    : hclk   - clock, rising edge
//             hreset - synchronous active-high reset
//             bus    - slave modport: request in, hrdata/hreadyout/hresp out
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 1
) (
    input  wire             hclk,
    input  wire             hreset,
    ahb_sram_slave_if.slave bus
);
    localparam int                    c_IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] c_DEPTH     = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [3:0]            c_WAIT_LOAD = 4'(WAIT_STATES - 1);
    localparam bit                    c_HAS_WAIT  = (WAIT_STATES > 0);

    logic [c_STATE_W-1:0] r_state_q, w_state_d;
    logic [3:0]           r_cnt_q,   w_cnt_d;
    logic [c_IDX_W-1:0]   r_idx_q,   w_idx_d;
    logic [1:0]           r_ofs_q,   w_ofs_d;
    logic                 r_write_q, w_write_d;
    logic [2:0]           r_size_q,  w_size_d;

    logic                  w_active, w_accept, w_err;
    logic                  w_hreadyout, w_hresp, w_rd_en;
    logic [3:0]            w_we;
    logic [DATA_WIDTH-1:0] w_rdata;

    assign w_active = (bus.htrans == c_HTRANS_NONSEQ) || (bus.htrans == c_HTRANS_SEQ);
    // Only sample an address phase while this slave is itself ready.
    assign w_accept = bus.hsel & w_active & bus.hready & w_hreadyout;

    assign w_err = ((bus.haddr >> 2) >= c_DEPTH)
                 || (bus.hsize > c_HSIZE_WORD)
                 || ((bus.hsize == c_HSIZE_HALF) && bus.haddr[0])
                 || ((bus.hsize == c_HSIZE_WORD) && (bus.haddr[1:0] != 2'b00));

    // ---------------- state register ----------------
    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_state_q <= c_ST_IDLE;
            r_cnt_q   <= 4'd0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    // ---------------- data-phase capture ----------------
    always_comb begin
        w_idx_d   = r_idx_q;
        w_ofs_d   = r_ofs_q;
        w_write_d = r_write_q;
        w_size_d  = r_size_q;
        if (w_accept) begin
            w_idx_d   = bus.haddr[c_IDX_W+1:2];
            w_ofs_d   = bus.haddr[1:0];
            w_write_d = bus.hwrite;
            w_size_d  = bus.hsize;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            r_idx_q   <= '0;
            r_ofs_q   <= 2'b00;
            r_write_q <= 1'b0;
            r_size_q  <= 3'b000;
        end else begin
            r_idx_q   <= w_idx_d;
            r_ofs_q   <= w_ofs_d;
            r_write_q <= w_write_d;
            r_size_q  <= w_size_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        case (r_state_q)
            // Every ready state can take a new (pipelined) address phase.
            c_ST_IDLE, c_ST_DATA, c_ST_ERR2: begin
                if (w_accept) begin
                    if (w_err) begin
                        w_state_d = c_ST_ERR1;
                    end else if (c_HAS_WAIT) begin
                        w_state_d = c_ST_WAIT;
                        w_cnt_d   = c_WAIT_LOAD;
                    end else begin
                        w_state_d = c_ST_DATA;
                    end
                end else begin
                    w_state_d = c_ST_IDLE;
                end
            end
            c_ST_WAIT: begin
                if (r_cnt_q == 4'd0) begin
                    w_state_d = c_ST_DATA;
                end else begin
                    w_cnt_d = r_cnt_q - 4'd1;
                end
            end
            c_ST_ERR1: w_state_d = c_ST_ERR2;
            default:   w_state_d = c_ST_IDLE;
        endcase
    end

    // ---------------- output decode ----------------
    always_comb begin
        w_hreadyout = 1'b1;
        w_hresp     = c_HRESP_OKAY;
        case (r_state_q)
            c_ST_WAIT: w_hreadyout = 1'b0;
            c_ST_ERR1: begin
                w_hreadyout = 1'b0;
                w_hresp     = c_HRESP_ERROR;
            end
            c_ST_ERR2: w_hresp = c_HRESP_ERROR;
            default: ;
        endcase
        w_rd_en = (r_state_q == c_ST_DATA) && !r_write_q;
        // A reset during the final write cycle drops the write.
        w_we    = ((r_state_q == c_ST_DATA) && r_write_q && !hreset)
                ? lane_mask(r_size_q, r_ofs_q) : 4'b0000;
    end

    assign bus.hreadyout = w_hreadyout;
    assign bus.hresp     = w_hresp;
    assign bus.hrdata    = w_rd_en ? w_rdata : '0;

    ahb_sram_slave_core #(
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (c_IDX_W)
    ) u_core (
        .clk     (hclk),
        .i_we    (w_we),
        .i_idx   (r_idx_q),
        .i_wdata (bus.hwdata),
        .o_rdata (w_rdata)
    );
endmodule
`default_nettype wire

// File: tb/tb_ahb_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_sram_slave
//  Purpose  : Self-checking bench: two responders (WAIT_STATES 1 and 0) on a
//             shared master with a response mux, checked against a byte-level
//             memory model and the transfer timing rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_sram_slave;
    import ahb_sram_slave_pkg::*;

    localparam int DEPTH = 256;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic hclk = 1'b0;
    logic hreset;
    always #5 hclk = ~hclk;

    ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus0 ();
    ahb_sram_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus1 ();

    ahb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(1))
        dut0 (.hclk(hclk), .hreset(hreset), .bus(bus0));
    ahb_sram_slave #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(0))
        dut1 (.hclk(hclk), .hreset(hreset), .bus(bus1));

    // Master side and decoder select (only changed while the bus is idle)
    logic        m_hsel;
    logic [31:0] m_haddr;
    logic [1:0]  m_htrans;
    logic        m_hwrite;
    logic [2:0]  m_hsize;
    logic [31:0] m_hwdata;
    logic        sel;

    logic        s_hready, s_hresp;
    logic [31:0] s_hrdata;
    assign s_hready = sel ? bus1.hreadyout : bus0.hreadyout;
    assign s_hresp  = sel ? bus1.hresp     : bus0.hresp;
    assign s_hrdata = sel ? bus1.hrdata    : bus0.hrdata;

    assign bus0.hsel = m_hsel & ~sel;   assign bus1.hsel = m_hsel & sel;
    assign bus0.haddr = m_haddr;        assign bus1.haddr = m_haddr;
    assign bus0.htrans = m_htrans;      assign bus1.htrans = m_htrans;
    assign bus0.hwrite = m_hwrite;      assign bus1.hwrite = m_hwrite;
    assign bus0.hsize = m_hsize;        assign bus1.hsize = m_hsize;
    assign bus0.hwdata = m_hwdata;      assign bus1.hwdata = m_hwdata;
    assign bus0.hready = s_hready;      assign bus1.hready = s_hready;

    logic [31:0] model [2][DEPTH];
    xfer_t       q [$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic xfer_t mk(input logic [31:0] a, input logic w, input logic [2:0] s,
                                 input logic [31:0] d);
        xfer_t t;
        t.addr = a; t.write = w; t.size = s; t.wdata = d;
        return t;
    endfunction

    function automatic bit is_err(input xfer_t t);
        return ((t.addr / 4) >= DEPTH) || (t.size > 3'd2)
            || ((t.size == 3'd1) && (t.addr % 2 != 0))
            || ((t.size == 3'd2) && (t.addr % 4 != 0));
    endfunction

    // Replace the bytes the access covers; everything else is kept.
    task automatic model_write(input int d, input xfer_t t);
        int nb, base, idx, b;
        nb   = 1 << t.size;
        base = (t.addr % 4) - ((t.addr % 4) % nb);
        idx  = t.addr / 4;
        for (int k = 0; k < nb; k++) begin
            b = base + k;
            model[d][idx][8*b +: 8] = t.wdata[8*b +: 8];
        end
    endtask

    function automatic xfer_t rand_xfer();
        xfer_t t;
        int r, sz, ofs;
        t.write = 1'($urandom_range(0, 1));
        t.wdata = $urandom;
        r = $urandom_range(0, 9);
        if (r == 0) begin
            t.size = 3'd2;
            t.addr = 32'h400 + ($urandom_range(0, 1023) << 2);
        end else if (r == 1) begin
            t.size = 3'($urandom_range(3, 7));
            t.addr = $urandom_range(0, 63) << 2;
        end else if (r == 2) begin
            t.size = 3'($urandom_range(1, 2));
            t.addr = ($urandom_range(0, 63) << 2) + ((t.size == 3'd1) ? 1 + 2 * $urandom_range(0, 1)
                                                                     : $urandom_range(1, 3));
        end else begin
            sz     = $urandom_range(0, 2);
            ofs    = $urandom_range(0, 3);
            ofs    = ofs - (ofs % (1 << sz));
            t.size = 3'(sz);
            t.addr = ($urandom_range(0, 63) << 2) + ofs;
        end
        return t;
    endfunction

    task automatic drive_addr(input bit v, input xfer_t a);
        m_hsel   = v;
        m_htrans = v ? c_HTRANS_NONSEQ : c_HTRANS_IDLE;
        m_haddr  = a.addr;
        m_hwrite = a.write;
        m_hsize  = a.size;
    endtask

    // Pipelined master: drains q to responder d, checking every completion.
    task automatic run_seq(input int d);
        xfer_t a, dp;
        bit    a_v, dp_v, acc, err;
        int    waits, ws, cyc;
        sel  = (d != 0);
        ws   = (d == 0) ? 1 : 0;
        a_v  = 0; dp_v = 0; waits = 0; cyc = 0;
        a    = mk(0, 0, 0, 0);
        dp   = a;
        @(posedge hclk); #1;
        if (q.size() > 0) begin a = q.pop_front(); a_v = 1; end
        drive_addr(a_v, a);
        while (a_v || dp_v) begin
            @(negedge hclk);
            cyc++;
            if (cyc > 4000) begin
                n_cmp++; n_bad++;
                $error("FAIL run_seq_timeout: observed %0d cycles required <= 4000", cyc);
                break;
            end
            acc = 0;
            if (dp_v) begin
                err = is_err(dp);
                if (!s_hready) begin
                    waits++;
                    chk("wait_hresp", 32'(s_hresp), 32'(err));
                end else begin
                    chk("wait_count", 32'(waits), err ? 32'd1 : 32'(ws));
                    chk("final_hresp", 32'(s_hresp), 32'(err));
                    if (!err && !dp.write) chk("rdata", s_hrdata, model[d][dp.addr / 4]);
                    else                   chk("rdata_zero", s_hrdata, 32'd0);
                    if (!err && dp.write) model_write(d, dp);
                    dp_v = 0;
                end
            end
            if (a_v && s_hready) acc = 1;
            @(posedge hclk); #1;
            if (acc) begin
                dp = a; dp_v = 1; waits = 0;
                m_hwdata = a.write ? a.wdata : $urandom;
                a_v = 0;
                if (q.size() > 0) begin a = q.pop_front(); a_v = 1; end
            end
            drive_addr(a_v, a);
        end
    endtask

    initial begin
        hreset = 1'b1;
        sel    = 1'b0;
        m_hwdata = 32'd0;
        drive_addr(0, mk(0, 0, 0, 0));
        repeat (3) @(posedge hclk);
        #1 hreset = 1'b0;
        @(negedge hclk);
        chk("rst_ready0", 32'(bus0.hreadyout), 32'd1);
        chk("rst_hresp0", 32'(bus0.hresp), 32'd0);
        chk("rst_rdata0", bus0.hrdata, 32'd0);
        chk("rst_ready1", 32'(bus1.hreadyout), 32'd1);
        chk("rst_hresp1", 32'(bus1.hresp), 32'd0);
        chk("rst_rdata1", bus1.hrdata, 32'd0);

        // Give both SRAMs known contents in words 0..63
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 64; k++) q.push_back(mk(k * 4, 1, c_HSIZE_WORD, $urandom));
            run_seq(d);
        end

        // One wait state: word write then read-back
        q.push_back(mk(32'h10, 1, c_HSIZE_WORD, 32'hDEADBEEF));
        q.push_back(mk(32'h10, 0, c_HSIZE_WORD, 0));
        run_seq(0);
        chk("model_deadbeef", model[0][4], 32'hDEADBEEF);

        // Zero wait states: back-to-back write/read, then a byte merge
        q.push_back(mk(32'h20, 1, c_HSIZE_WORD, 32'h11223344));
        q.push_back(mk(32'h20, 0, c_HSIZE_WORD, 0));
        q.push_back(mk(32'h21, 1, c_HSIZE_BYTE, ($urandom & 32'hFFFF00FF) | 32'h0000AA00));
        q.push_back(mk(32'h20, 0, c_HSIZE_WORD, 0));
        run_seq(1);
        chk("model_byte_merge", model[1][8], 32'h1122AA44);

        // Out-of-range read and misaligned word write
        q.push_back(mk(32'h400, 0, c_HSIZE_WORD, 0));
        q.push_back(mk(32'h02, 1, c_HSIZE_WORD, 32'h5A5A5A5A));
        q.push_back(mk(32'h00, 0, c_HSIZE_WORD, 0));
        run_seq(0);

        // Reset in the wait cycle of a write: transfer aborted, SRAM untouched
        sel = 1'b0;
        @(posedge hclk); #1;
        drive_addr(1, mk(32'h30, 1, c_HSIZE_WORD, 0));
        @(posedge hclk); #1;
        drive_addr(0, mk(0, 0, 0, 0));
        m_hwdata = 32'hCAFEF00D;
        hreset   = 1'b1;
        @(negedge hclk);
        chk("rst_mid_wait", 32'(s_hready), 32'd0);
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(negedge hclk);
        chk("rst_mid_ready", 32'(s_hready), 32'd1);
        chk("rst_mid_hresp", 32'(s_hresp), 32'd0);
        chk("rst_mid_rdata", s_hrdata, 32'd0);
        q.push_back(mk(32'h30, 0, c_HSIZE_WORD, 0));
        run_seq(0);

        // Randomized mixed traffic on both responders
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 80; k++) q.push_back(rand_xfer());
            run_seq(d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
